// File: rtl/axil_default_slave.sv
// ----------------------------------------------------------------------------
// axil_default_slave
//   AXI4-Lite default (error) slave. Terminates every write and read that the
//   interconnect routes to an unmapped address and answers with RESP_CODE.
//   Reads return a fixed data pattern. Saturating error counters and the last
//   offending addresses are exposed for debug/CSR use.
//
// Ports
//   aclk, aresetn            clock, synchronous active-low reset
//   s_axil_aw* / s_axil_w*   write address / data channels (data ignored)
//   s_axil_b*                write response channel
//   s_axil_ar* / s_axil_r*   read address / data channels
//   clr_cnt                  synchronous clear of both error counters
//   err_wr_cnt, err_rd_cnt   completed erroneous writes / reads, saturating
//   last_wr_addr             address of the most recently accepted AW
//   last_rd_addr             address of the most recently accepted AR
//   err_pulse                one-cycle pulse after any AW or AR acceptance
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module axil_default_slave #(
  parameter int          ADDR_WIDTH    = 32,
  parameter int          DATA_WIDTH    = 32,
  parameter logic [1:0]  RESP_CODE     = 2'b11,
  parameter logic [31:0] RDATA_PATTERN = 32'hDEAD_BEEF,
  parameter int          CNT_WIDTH     = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                    s_axil_awvalid,
  output logic                    s_axil_awready,
  input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
  input  logic                    s_axil_wvalid,
  output logic                    s_axil_wready,
  output logic [1:0]              s_axil_bresp,
  output logic                    s_axil_bvalid,
  input  logic                    s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  input  logic                    clr_cnt,
  output logic [CNT_WIDTH-1:0]    err_wr_cnt,
  output logic [CNT_WIDTH-1:0]    err_rd_cnt,
  output logic [ADDR_WIDTH-1:0]   last_wr_addr,
  output logic [ADDR_WIDTH-1:0]   last_rd_addr,
  output logic                    err_pulse
);

  // Pattern is zero-extended or truncated to the bus width.
  localparam logic [DATA_WIDTH-1:0] RDATA_VAL = DATA_WIDTH'(RDATA_PATTERN);

  typedef enum logic {W_COLLECT, W_RESP} wr_state_t;
  typedef enum logic {R_ADDR, R_DATA} rd_state_t;

  wr_state_t wr_state, wr_state_nxt;
  rd_state_t rd_state, rd_state_nxt;

  logic got_aw, got_aw_nxt;
  logic got_w, got_w_nxt;
  logic awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0] bresp_nxt;
  logic arready_nxt, rvalid_nxt;
  logic [1:0] rresp_nxt;
  logic [DATA_WIDTH-1:0] rdata_nxt;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Write data is never inspected; fold it into a sink so it is not flagged.
  logic unused_wdata;
  assign unused_wdata = ^{s_axil_wdata, s_axil_wstrb};

  assign aw_hs = s_axil_awvalid & s_axil_awready;
  assign w_hs  = s_axil_wvalid  & s_axil_wready;
  assign b_hs  = s_axil_bvalid  & s_axil_bready;
  assign ar_hs = s_axil_arvalid & s_axil_arready;
  assign r_hs  = s_axil_rvalid  & s_axil_rready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] cnt,
                                                   input logic                 en);
    return (en && (cnt != {CNT_WIDTH{1'b1}})) ? cnt + 1'b1 : cnt;
  endfunction

  // Write FSM: AW and W collected independently, response once both seen.
  always_comb begin
    wr_state_nxt = wr_state;
    got_aw_nxt   = got_aw;
    got_w_nxt    = got_w;
    awready_nxt  = s_axil_awready;
    wready_nxt   = s_axil_wready;
    bvalid_nxt   = s_axil_bvalid;
    bresp_nxt    = s_axil_bresp;
    case (wr_state)
      W_COLLECT: begin
        got_aw_nxt  = got_aw | aw_hs;
        got_w_nxt   = got_w | w_hs;
        // Ready stays up until its own channel has been accepted; this also
        // raises both readies on the first cycle out of reset.
        awready_nxt = ~got_aw_nxt;
        wready_nxt  = ~got_w_nxt;
        if (got_aw_nxt && got_w_nxt) begin
          wr_state_nxt = W_RESP;
          bvalid_nxt   = 1'b1;
          bresp_nxt    = RESP_CODE;
        end
      end
      W_RESP: begin
        if (s_axil_bready) begin
          wr_state_nxt = W_COLLECT;
          got_aw_nxt   = 1'b0;
          got_w_nxt    = 1'b0;
          awready_nxt  = 1'b1;
          wready_nxt   = 1'b1;
          bvalid_nxt   = 1'b0;
          bresp_nxt    = 2'b00;
        end
      end
    endcase
  end

  // Read FSM: single outstanding read, answered the cycle after AR.
  always_comb begin
    rd_state_nxt = rd_state;
    arready_nxt  = s_axil_arready;
    rvalid_nxt   = s_axil_rvalid;
    rdata_nxt    = s_axil_rdata;
    rresp_nxt    = s_axil_rresp;
    case (rd_state)
      R_ADDR: begin
        arready_nxt = ~ar_hs;
        if (ar_hs) begin
          rd_state_nxt = R_DATA;
          rvalid_nxt   = 1'b1;
          rdata_nxt    = RDATA_VAL;
          rresp_nxt    = RESP_CODE;
        end
      end
      R_DATA: begin
        if (s_axil_rready) begin
          rd_state_nxt = R_ADDR;
          arready_nxt  = 1'b1;
          rvalid_nxt   = 1'b0;
          rdata_nxt    = '0;
          rresp_nxt    = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_state       <= W_COLLECT;
      rd_state       <= R_ADDR;
      got_aw         <= 1'b0;
      got_w          <= 1'b0;
      s_axil_awready <= 1'b0;
      s_axil_wready  <= 1'b0;
      s_axil_bvalid  <= 1'b0;
      s_axil_bresp   <= 2'b00;
      s_axil_arready <= 1'b0;
      s_axil_rvalid  <= 1'b0;
      s_axil_rdata   <= '0;
      s_axil_rresp   <= 2'b00;
      err_wr_cnt     <= '0;
      err_rd_cnt     <= '0;
      last_wr_addr   <= '0;
      last_rd_addr   <= '0;
      err_pulse      <= 1'b0;
    end else begin
      wr_state       <= wr_state_nxt;
      rd_state       <= rd_state_nxt;
      got_aw         <= got_aw_nxt;
      got_w          <= got_w_nxt;
      s_axil_awready <= awready_nxt;
      s_axil_wready  <= wready_nxt;
      s_axil_bvalid  <= bvalid_nxt;
      s_axil_bresp   <= bresp_nxt;
      s_axil_arready <= arready_nxt;
      s_axil_rvalid  <= rvalid_nxt;
      s_axil_rdata   <= rdata_nxt;
      s_axil_rresp   <= rresp_nxt;
      err_pulse      <= aw_hs | ar_hs;
      if (aw_hs) last_wr_addr <= s_axil_awaddr;
      if (ar_hs) last_rd_addr <= s_axil_araddr;
      // Clear takes priority over a same-cycle completion.
      if (clr_cnt) begin
        err_wr_cnt <= '0;
        err_rd_cnt <= '0;
      end else begin
        err_wr_cnt <= sat_inc(err_wr_cnt, b_hs);
        err_rd_cnt <= sat_inc(err_rd_cnt, r_hs);
      end
    end
  end

endmodule

// File: tb/tb_axil_default_slave.sv
`timescale 1ns/1ps
module tb_axil_default_slave;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 2;

  logic          aclk = 1'b0;
  logic          aresetn;
  logic [AW-1:0] awaddr;
  logic          awvalid, awready;
  logic [DW-1:0] wdata;
  logic [DW/8-1:0] wstrb;
  logic          wvalid, wready;
  logic [1:0]    bresp;
  logic          bvalid, bready;
  logic [AW-1:0] araddr;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic          clr_cnt;
  logic [CW-1:0] err_wr_cnt, err_rd_cnt;
  logic [AW-1:0] last_wr_addr, last_rd_addr;
  logic          err_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 aclk = ~aclk;

  axil_default_slave #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_CODE(2'b11),
    .RDATA_PATTERN(32'hDEAD_BEEF), .CNT_WIDTH(CW)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb),
    .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp),
    .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .clr_cnt(clr_cnt), .err_wr_cnt(err_wr_cnt), .err_rd_cnt(err_rd_cnt),
    .last_wr_addr(last_wr_addr), .last_rd_addr(last_rd_addr),
    .err_pulse(err_pulse)
  );

  // Advance one clock; outputs are sampled and inputs driven 1 ns after the edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Same-cycle AW+W with bready high; checks the counter afterwards.
  task automatic do_write(input logic [AW-1:0] addr, input logic [CW-1:0] exp_cnt);
    awaddr = addr; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    chk("sat_bvalid", bvalid, 1);
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    chk("sat_bdone", bvalid, 0);
    chk("sat_cnt", err_wr_cnt, exp_cnt);
    bready = 1'b0;
  endtask

  initial begin
    aresetn = 1'b0; awaddr = '0; awvalid = 1'b0; wdata = 32'h1234_5678; wstrb = 4'hF;
    wvalid = 1'b0; bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    clr_cnt = 1'b0;
    tick(); tick(); tick();

    // Reset state
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_pulse", err_pulse, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_wcnt", err_wr_cnt, 0);
    chk("rst_lastwr", last_wr_addr, 0);

    aresetn = 1'b1;
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);

    // Same-cycle AW+W
    awaddr = 32'h4000_0010; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t1_bvalid", bvalid, 1);
    chk("t1_bresp", bresp, 2'b11);
    chk("t1_awready", awready, 0);
    chk("t1_wready", wready, 0);
    chk("t1_pulse", err_pulse, 1);
    chk("t1_lastwr", last_wr_addr, 32'h4000_0010);
    tick();
    chk("t1_bdone", bvalid, 0);
    chk("t1_bresp0", bresp, 0);
    chk("t1_cnt", err_wr_cnt, 1);
    chk("t1_pulse_end", err_pulse, 0);
    chk("t1_awready_up", awready, 1);
    chk("t1_wready_up", wready, 1);
    bready = 1'b0;

    // AW first, W three cycles later, bready held low
    awaddr = 32'h1234_5678; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t2_awready", awready, 0);
    chk("t2_pulse", err_pulse, 1);
    chk("t2_lastwr", last_wr_addr, 32'h1234_5678);
    chk("t2_nob", bvalid, 0);
    tick();
    chk("t2_wready_wait", wready, 1);
    chk("t2_nob2", bvalid, 0);
    chk("t2_pulse_off", err_pulse, 0);
    tick();
    chk("t2_nob3", bvalid, 0);
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t2_bvalid", bvalid, 1);
    chk("t2_wready", wready, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t2_hold_bvalid", bvalid, 1);
      chk("t2_hold_bresp", bresp, 2'b11);
      chk("t2_hold_awready", awready, 0);
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t2_bdone", bvalid, 0);
    chk("t2_awready_up", awready, 1);
    chk("t2_wready_up", wready, 1);
    chk("t2_cnt", err_wr_cnt, 2);
    tick();
    chk("t2_single_b", bvalid, 0);
    chk("t2_cnt_hold", err_wr_cnt, 2);

    // W first, AW two cycles later
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t3_wready", wready, 0);
    chk("t3_nob", bvalid, 0);
    chk("t3_nopulse", err_pulse, 0);
    tick();
    chk("t3_wready2", wready, 0);
    awaddr = 32'hCAFE_0004; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("t3_bvalid", bvalid, 1);
    chk("t3_pulse", err_pulse, 1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    chk("t3_bdone", bvalid, 0);
    chk("t3_cnt", err_wr_cnt, 3);
    tick();
    chk("t3_single_b", bvalid, 0);

    // Read
    araddr = 32'h8000_0000; arvalid = 1'b1; rready = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("t4_arready", arready, 0);
    chk("t4_rvalid", rvalid, 1);
    chk("t4_rdata", rdata, 32'hDEAD_BEEF);
    chk("t4_rresp", rresp, 2'b11);
    chk("t4_lastrd", last_rd_addr, 32'h8000_0000);
    chk("t4_pulse", err_pulse, 1);
    tick();
    rready = 1'b0;
    chk("t4_rdone", rvalid, 0);
    chk("t4_rdata0", rdata, 0);
    chk("t4_rresp0", rresp, 0);
    chk("t4_rcnt", err_rd_cnt, 1);
    chk("t4_arready_up", arready, 1);

    // Clear counters
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    chk("clr_wcnt", err_wr_cnt, 0);
    chk("clr_rcnt", err_rd_cnt, 0);

    // Concurrent write and read, AW+AR same cycle
    awaddr = 32'h1111_0000; araddr = 32'h2222_0000; awvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    chk("t5_pulse", err_pulse, 1);
    chk("t5_rvalid", rvalid, 1);
    chk("t5_lastwr", last_wr_addr, 32'h1111_0000);
    chk("t5_lastrd", last_rd_addr, 32'h2222_0000);
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("t5_single_pulse", err_pulse, 0);
    chk("t5_bvalid", bvalid, 1);
    chk("t5_rvalid_hold", rvalid, 1);
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    chk("t5_bdone", bvalid, 0);
    chk("t5_rdone", rvalid, 0);
    chk("t5_wcnt", err_wr_cnt, 1);
    chk("t5_rcnt", err_rd_cnt, 1);

    // Saturation at 3 with a 2-bit counter
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
    do_write(32'h0000_0100, 1);
    do_write(32'h0000_0104, 2);
    do_write(32'h0000_0108, 3);
    do_write(32'h0000_010C, 3);
    do_write(32'h0000_0110, 3);

    // Clear wins over a same-cycle B handshake
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("t6_bvalid", bvalid, 1);
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0; bready = 1'b0;
    chk("t6_clr_wins", err_wr_cnt, 0);
    chk("t6_bdone", bvalid, 0);

    // Reset with responses pending
    awaddr = 32'h5555_0000; araddr = 32'h6666_0000;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("t7_bvalid", bvalid, 1);
    chk("t7_rvalid", rvalid, 1);
    aresetn = 1'b0;
    tick();
    chk("t7_rst_bvalid", bvalid, 0);
    chk("t7_rst_rvalid", rvalid, 0);
    chk("t7_rst_lastwr", last_wr_addr, 0);
    chk("t7_rst_awready", awready, 0);
    aresetn = 1'b1; bready = 1'b1; rready = 1'b1;
    tick();
    chk("t7_no_b", bvalid, 0);
    chk("t7_no_r", rvalid, 0);
    chk("t7_awready", awready, 1);
    tick();
    chk("t7_no_b2", bvalid, 0);
    chk("t7_wcnt", err_wr_cnt, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
